// File: rtl/gpr_writeback_arbiter_if.sv
// Writeback request and register-file write port bundle for the GPR
// writeback arbiter. The master side is the request producer and register
// file consumer. The slave side is the arbiter itself.
interface gpr_writeback_arbiter_if #(
  parameter int CW = 3
);
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_reg;
  logic [31:0]   mem_data;
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_reg;
  logic [31:0]   alu_data;
  logic [4:0]    write_register;
  logic [31:0]   w_data;
  logic          regWrite;
  logic [31:0]   pending_mask;
  logic [CW-1:0] count;

  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
    input  mem_ready, alu_ready, write_register, w_data, regWrite,
           pending_mask, count
  );

  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
    output mem_ready, alu_ready, write_register, w_data, regWrite,
           pending_mask, count
  );
endinterface

// File: rtl/gpr_writeback_arbiter.sv
// GPR writeback arbiter. Load-path and ALU writeback requests are merged in
// acceptance order into a small FIFO. The FIFO drains one register-file write
// per cycle. A pending-destination mask lets decode stall on in-flight
// registers.
module gpr_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  gpr_writeback_arbiter_if.slave bus
);
  localparam int PW = CW - 1;

  // Handshake: a request transfers on a rising edge where valid && ready.
  // Ready depends only on registered state (and, for the ALU, on mem_valid).
  // A producer holds valid and its payload stable until the transfer happens.

  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_reg_q, wr_reg_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [31:0]   mask;

  logic          full;
  logic          mem_fire;
  logic          alu_fire;
  logic [4:0]    push_reg;
  logic [31:0]   push_data;
  logic          push;
  logic          pop;

  // A pop in the same cycle never frees a slot for a push.
  assign full          = (count_q == CW'(DEPTH));
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;

  // The load path has priority. The two fires are mutually exclusive.
  assign mem_fire  = bus.mem_valid && !full;
  assign alu_fire  = bus.alu_valid && bus.alu_ready;
  assign push_reg  = mem_fire ? bus.mem_reg  : bus.alu_reg;
  assign push_data = mem_fire ? bus.mem_data : bus.alu_data;

  // A write to r0 is accepted and dropped. It is never queued.
  assign push = (mem_fire || alu_fire) && (push_reg != 5'd0);
  assign pop  = (count_q != '0);

  // Next-state for pointers, occupancy and the registered write port.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = reg_mem[head_q];
      wr_data_d = data_mem[head_q];
      head_d    = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset. Reset discards every queued write.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO payload storage. Entries are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      reg_mem[tail_q]  <= push_reg;
      data_mem[tail_q] <= push_data;
    end
  end

  // Pending mask: every live FIFO entry plus the write being presented now.
  always_comb begin
    mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        mask[reg_mem[head_q + PW'(i)]] = 1'b1;
      end
    end
    if (wr_en_q) begin
      mask[wr_reg_q] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign bus.pending_mask   = mask;
  assign bus.count          = count_q;
  assign bus.regWrite       = wr_en_q;
  assign bus.write_register = wr_reg_q;
  assign bus.w_data         = wr_data_q;
endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Testbench for gpr_writeback_arbiter. Directed scenarios plus a randomized
// run, all compared against a queue-level reference model of the arbiter.
module tb_gpr_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  gpr_writeback_arbiter_if #(.CW(CW)) bus ();

  gpr_writeback_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued writes in acceptance order and the write presented.
  logic [36:0] exp_q[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_reg  = 5'd0;
  logic [31:0] m_data = 32'd0;

  always @(posedge clk) begin
    logic        room;
    logic [36:0] e;
    if (reset) begin
      exp_q.delete();
      m_we   = 1'b0;
      m_reg  = 5'd0;
      m_data = 32'd0;
    end else begin
      room = (exp_q.size() < DEPTH);
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        m_we   = 1'b1;
        m_reg  = e[36:32];
        m_data = e[31:0];
      end else begin
        m_we = 1'b0;
      end
      if (room && bus.mem_valid) begin
        if (bus.mem_reg != 5'd0) exp_q.push_back({bus.mem_reg, bus.mem_data});
      end else if (room && bus.alu_valid) begin
        if (bus.alu_reg != 5'd0) exp_q.push_back({bus.alu_reg, bus.alu_data});
      end
    end
  end

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = 32'd0;
    foreach (exp_q[i]) m[exp_q[i][36:32]] = 1'b1;
    if (m_we) m[m_reg] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic idle_inputs();
    bus.mem_valid = 1'b0;
    bus.mem_reg   = 5'd0;
    bus.mem_data  = 32'd0;
    bus.alu_valid = 1'b0;
    bus.alu_reg   = 5'd0;
    bus.alu_data  = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite cyc %0d: got %b want 0", c, bus.regWrite); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count cyc %0d: got %0d want 0", c, bus.count); end
      checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL reset_mask cyc %0d: got %h want 0", c, bus.pending_mask); end
      checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready cyc %0d: got %b%b want 11", c, bus.mem_ready, bus.alu_ready); end
    end
    checks++; if (bus.write_register !== 5'd0 || bus.w_data !== 32'd0) begin errors++; $display("FAIL reset_port: got r%0d %h want r0 0", bus.write_register, bus.w_data); end
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.alu_ready); end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.count); end
    checks++; if (bus.pending_mask !== 32'h20) begin errors++; $display("FAIL single_mask_q: got %h want 20", bus.pending_mask); end
    checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bus.regWrite); end
    @(negedge clk);
    checks++; if (bus.regWrite !== 1'b1 || bus.write_register !== 5'd5 || bus.w_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write: got we=%b r%0d %h want we=1 r5 deadbeef", bus.regWrite, bus.write_register, bus.w_data); end
    checks++; if (bus.pending_mask !== 32'h20) begin errors++; $display("FAIL single_mask_p: got %h want 20", bus.pending_mask); end
    @(negedge clk);
    checks++; if (bus.regWrite !== 1'b0 || bus.pending_mask !== 32'd0) begin errors++; $display("FAIL single_done: got we=%b mask=%h want 0 0", bus.regWrite, bus.pending_mask); end
    checks++; if (bus.write_register !== 5'd5 || bus.w_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: got r%0d %h want r5 deadbeef", bus.write_register, bus.w_data); end
  endtask

  task automatic test_collision();
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd3; bus.mem_data = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd4; bus.alu_data = 32'h22;
    #1;
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got mem=%b alu=%b want 1 0", bus.mem_ready, bus.alu_ready); end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL coll_alu_ready: got %b want 1", bus.alu_ready); end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    checks++; if (bus.regWrite !== 1'b1 || bus.write_register !== 5'd3 || bus.w_data !== 32'h11) begin
      errors++; $display("FAIL coll_first: got we=%b r%0d %h want r3 11", bus.regWrite, bus.write_register, bus.w_data); end
    @(negedge clk);
    checks++; if (bus.regWrite !== 1'b1 || bus.write_register !== 5'd4 || bus.w_data !== 32'h22) begin
      errors++; $display("FAIL coll_second: got we=%b r%0d %h want r4 22", bus.regWrite, bus.write_register, bus.w_data); end
    @(negedge clk);
  endtask

  task automatic test_full_burst();
    int   idx  = 0;
    int   seen = 0;
    logic fired;
    for (int cyc = 0; cyc < 20; cyc++) begin
      checks++; if (bus.count !== CW'(exp_q.size()) || bus.count > 3'd4) begin errors++; $display("FAIL burst_count cyc %0d: got %0d want %0d", cyc, bus.count, exp_q.size()); end
      if (bus.regWrite === 1'b1) begin
        checks++; if (seen >= 5 || bus.write_register !== 5'(8 + seen) || bus.w_data !== 32'hA0 + 32'(seen)) begin
          errors++; $display("FAIL burst_order #%0d: got r%0d %h want r%0d %h", seen, bus.write_register, bus.w_data, 8 + seen, 32'hA0 + 32'(seen)); end
        seen++;
      end
      if (idx < 5) begin
        bus.mem_valid = 1'b1; bus.mem_reg = 5'(8 + idx); bus.mem_data = 32'hA0 + 32'(idx);
      end else begin
        bus.mem_valid = 1'b0;
      end
      #1;
      checks++; if (bus.mem_ready !== (exp_q.size() < DEPTH)) begin errors++; $display("FAIL burst_ready cyc %0d: got %b want %b", cyc, bus.mem_ready, exp_q.size() < DEPTH); end
      fired = bus.mem_valid && bus.mem_ready;
      @(negedge clk);
      if (fired) idx++;
    end
    checks++; if (seen != 5) begin errors++; $display("FAIL burst_total: got %0d writes want 5", seen); end
  endtask

  task automatic test_reg0_dup();
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd0; bus.mem_data = 32'hFFFF;
    @(negedge clk);
    checks++; if (bus.count !== 3'd0 || bus.pending_mask !== 32'd0) begin errors++; $display("FAIL r0_enq: got count=%0d mask=%h want 0 0", bus.count, bus.pending_mask); end
    bus.mem_reg = 5'd7; bus.mem_data = 32'd1;
    @(negedge clk);
    checks++; if (bus.count !== 3'd1 || bus.pending_mask !== 32'h80) begin errors++; $display("FAIL dup_q1: got count=%0d mask=%h want 1 80", bus.count, bus.pending_mask); end
    bus.mem_data = 32'd2;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    checks++; if (bus.regWrite !== 1'b1 || bus.write_register !== 5'd7 || bus.w_data !== 32'd1) begin
      errors++; $display("FAIL dup_first: got we=%b r%0d %h want r7 1", bus.regWrite, bus.write_register, bus.w_data); end
    checks++; if (bus.pending_mask !== 32'h80) begin errors++; $display("FAIL dup_mask1: got %h want 80", bus.pending_mask); end
    @(negedge clk);
    checks++; if (bus.regWrite !== 1'b1 || bus.write_register !== 5'd7 || bus.w_data !== 32'd2) begin
      errors++; $display("FAIL dup_second: got we=%b r%0d %h want r7 2", bus.regWrite, bus.write_register, bus.w_data); end
    checks++; if (bus.pending_mask !== 32'h80 || bus.count !== 3'd0) begin errors++; $display("FAIL dup_mask2: got mask=%h count=%0d want 80 0", bus.pending_mask, bus.count); end
    @(negedge clk);
    checks++; if (bus.regWrite !== 1'b0 || bus.pending_mask !== 32'd0) begin errors++; $display("FAIL dup_done: got we=%b mask=%h want 0 0", bus.regWrite, bus.pending_mask); end
  endtask

  task automatic test_mid_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.mem_valid = 1'b1; bus.mem_reg = 5'(i); bus.mem_data = 32'h100 + 32'(i);
      @(negedge clk);
    end
    bus.mem_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.regWrite !== 1'b0 || bus.count !== 3'd0 || bus.pending_mask !== 32'd0) begin
      errors++; $display("FAIL midrst_state: got we=%b count=%0d mask=%h want 0 0 0", bus.regWrite, bus.count, bus.pending_mask); end
    checks++; if (bus.write_register !== 5'd0 || bus.w_data !== 32'd0) begin errors++; $display("FAIL midrst_port: got r%0d %h want r0 0", bus.write_register, bus.w_data); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.regWrite !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL midrst_ghost cyc %0d: got we=%b r%0d count=%0d want 0", c, bus.regWrite, bus.write_register, bus.count); end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (bus.count !== CW'(exp_q.size())) begin errors++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, bus.count, exp_q.size()); end
      checks++; if (bus.regWrite !== m_we) begin errors++; $display("FAIL rnd_we cyc %0d: got %b want %b", cyc, bus.regWrite, m_we); end
      checks++; if (bus.write_register !== m_reg || bus.w_data !== m_data) begin
        errors++; $display("FAIL rnd_port cyc %0d: got r%0d %h want r%0d %h", cyc, bus.write_register, bus.w_data, m_reg, m_data); end
      checks++; if (bus.pending_mask !== model_mask()) begin errors++; $display("FAIL rnd_mask cyc %0d: got %h want %h", cyc, bus.pending_mask, model_mask()); end
      reset         = ($urandom_range(0, 63) == 0);
      bus.mem_valid = ($urandom_range(0, 2) == 0);
      bus.mem_reg   = 5'($urandom_range(0, 31));
      bus.mem_data  = $urandom;
      bus.alu_valid = ($urandom_range(0, 1) == 0);
      bus.alu_reg   = 5'($urandom_range(0, 31));
      bus.alu_data  = $urandom;
      #1;
      checks++; if (bus.mem_ready !== (exp_q.size() < DEPTH) || bus.alu_ready !== ((exp_q.size() < DEPTH) && !bus.mem_valid)) begin
        errors++; $display("FAIL rnd_ready cyc %0d: got %b%b", cyc, bus.mem_ready, bus.alu_ready); end
      @(negedge clk);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_full_burst();
    test_reg0_dup();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
